gate_truth_sequencer: RTL
=========================

Name: gate_truth_sequencer

Overview:
- Controller that drives a 2-input logic gate under test (AND/OR/NAND/NOR/XOR/XNOR family) through all four input combinations.
- Holds each combination for a programmable dwell time, samples the gate output and compares it against the expected truth table.
- Reports pass/fail per combination.
- Sits between the board switches/buttons (Nexys A7, 100 MHz) and the gate modules; outputs go to LEDs.

Parameters:
- TICK_DIV, 100_000_000: dwell cycles per input combination (1 s at 100 MHz); legal range ≥1; simulation uses 4.

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- start  input  1  run request (debounced button); rising edge detected internally
- gate_sel  input  3  gate type: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6–7 invalid
- gate_out  input  1  output of the gate under test
- in_a  output  1  gate input A (registered)
- in_b  output  1  gate input B (registered)
- step  output  2  current combination index, {in_a,in_b}
- busy  output  1  run in progress
- done  output  1  result valid
- pass  output  1  last run had zero mismatches
- fail_mask  output  4  bit i set ⇒ combination i mismatched in last run

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; start edge detector register cleared.
- start_rise = start & ~start_q. It is ignored while busy=1.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - in_a = in_b = 0.
  - On start_rise: latch gate_sel into sel_q, clear the internal mask acc, step=0, dwell counter=0, busy=1, done=0, go to DRIVE.
  - If gate_sel ≥ 6: go straight to DONE the next cycle with fail_mask=4'hF, pass=0, done=1, busy=0. in_a/in_b stay 0.
- DRIVE:
  - {in_a,in_b} = step, registered, so the gate sees the new value in the first dwell cycle.
  - The counter counts 0..TICK_DIV-1.
  - On the cycle where counter==TICK_DIV-1: compare gate_out against expected(sel_q, step); on mismatch set acc[step].
  - Then if step==3, go to DONE. Otherwise increment step and reset the counter.
- DONE:
  - fail_mask = final acc, including the step-3 compare; pass = (fail_mask==0); done=1; busy=0.
  - in_a/in_b return to 0. Results held.
  - start_rise starts a new run exactly as from IDLE. The new run clears done on entry; fail_mask/pass are held until the new run completes.
- Latency: start_rise seen at edge k ⇒ DRIVE from k+1; done=1 at edge k+1+4·TICK_DIV.
- TICK_DIV=1: one cycle per combination, sampling happens in that same cycle.
- gate_sel changes mid-run have no effect, because sel_q is used.
- start held high gives only one run; a re-press during busy is ignored.
- Reset mid-run: immediate return to all-zero outputs and IDLE; no partial result.

Optional Feature:
- Macro GATE_SEQ_AUTO_REPEAT_EN.
- Defined: on completing step 3, results update, done pulses high for one cycle, and a new run with the same sel_q starts immediately if start is still high (step=0, counter=0, acc cleared, busy stays 1). If start is low, stay in DONE.
- Undefined: one run per start rising edge; done is a held level.

Decomposition:
- Package gate_seq_pkg:
  - gate-type localparams (GATE_AND…GATE_XNOR, GATE_INVALID_MIN=6)
  - state encoding
  - function expected_out(sel, a, b)
- Sub-module dwell_timer:
  - parameter TICK_DIV
  - inputs clear and enable
  - output last, high on counter==TICK_DIV-1
- The controller FSM and result registers remain in gate_truth_sequencer.

Test Plan (TICK_DIV=4):
- gate_sel=3, gate_out driven by a correct NOR of in_a/in_b, start pulse → {in_a,in_b}=00,01,10,11, 4 cycles each; done=1 16 cycles after DRIVE entry; pass=1, fail_mask=0000.
- gate_sel=3, gate_out wired to OR model → fail_mask=1111, pass=0.
- gate_sel=0 (AND), gate_out stuck at 0 → fail_mask=1000, pass=0.
- gate_sel=7, start pulse → done=1 one cycle after DRIVE would start; fail_mask=1111; in_a=in_b=0 throughout; busy never observed high beyond entry.
- Mid-run re-press of start and a gate_sel change at step 1 → no effect, result matches the original sel. rst_n low during step 2 → all outputs 0 asynchronously, IDLE; a subsequent start produces a full clean run.
- GATE_SEQ_AUTO_REPEAT_EN defined, start held high, correct XOR model → consecutive runs back-to-back, done one-cycle pulse every 16 cycles. Release start → stops in DONE after the current run, pass=1.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate truth-table sequencer: gate codes, FSM states and the
// reference truth function used when judging the gate under test.
package gate_seq_pkg;

  localparam logic [2:0] GATE_AND         = 3'd0;
  localparam logic [2:0] GATE_OR          = 3'd1;
  localparam logic [2:0] GATE_NAND        = 3'd2;
  localparam logic [2:0] GATE_NOR         = 3'd3;
  localparam logic [2:0] GATE_XOR         = 3'd4;
  localparam logic [2:0] GATE_XNOR        = 3'd5;
  localparam logic [2:0] GATE_INVALID_MIN = 3'd6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StDone  = 2'd2
  } state_e;

  function automatic logic expected_out(input logic [2:0] sel, input logic a, input logic b);
    logic r;
    case (sel)
      GATE_AND:  r = a & b;
      GATE_OR:   r = a | b;
      GATE_NAND: r = ~(a & b);
      GATE_NOR:  r = ~(a | b);
      GATE_XOR:  r = a ^ b;
      GATE_XNOR: r = ~(a ^ b);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..TICK_DIV-1 while enabled, wraps, and flags the final cycle.
module dwell_timer #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = last ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_truth_sequencer.sv
// Walks a 2-input gate through all four input combinations and records mismatches.
// Define GATE_SEQ_AUTO_REPEAT_EN to restart runs back-to-back while start is held.
module gate_truth_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       gate_out,
  output logic       in_a,
  output logic       in_b,
  output logic [1:0] step,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [1:0] step_q, step_d;
  logic [1:0] in_q, in_d;
  logic [3:0] acc_q, acc_d, acc_upd;
  logic [3:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       start_q;
  logic       start_rise, mismatch, sel_valid;
  logic       tmr_clear, tmr_en, tmr_last;

  dwell_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmr_clear),
    .enable(tmr_en),
    .last  (tmr_last)
  );

  assign start_rise = start & ~start_q;
  assign sel_valid  = (sel_q < GATE_INVALID_MIN);
  assign mismatch   = (gate_out != expected_out(sel_q, step_q[1], step_q[0]));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    step_d    = step_q;
    acc_d     = acc_q;
    fail_d    = fail_q;
    pass_d    = pass_q;
    busy_d    = busy_q;
`ifdef GATE_SEQ_AUTO_REPEAT_EN
    done_d    = 1'b0;
`else
    done_d    = done_q;
`endif
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    acc_upd   = acc_q;
    acc_upd[step_q] = acc_q[step_q] | mismatch;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_rise) begin
          sel_d     = gate_sel;
          step_d    = 2'd0;
          acc_d     = 4'h0;
          tmr_clear = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          state_d   = StDrive;
        end
      end
      StDrive: begin
        if (!sel_valid) begin
          fail_d  = 4'hF;
          pass_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          tmr_en = 1'b1;
          if (tmr_last) begin
            acc_d = acc_upd;
            if (step_q == 2'd3) begin
              fail_d = acc_upd;
              pass_d = (acc_upd == 4'h0);
              done_d = 1'b1;
`ifdef GATE_SEQ_AUTO_REPEAT_EN
              if (start) begin
                // Timer has wrapped to 0 already; just rewind the run.
                step_d = 2'd0;
                acc_d  = 4'h0;
              end else begin
                busy_d  = 1'b0;
                state_d = StDone;
              end
`else
              busy_d  = 1'b0;
              state_d = StDone;
`endif
            end else begin
              step_d = step_q + 2'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered gate inputs track the step the next cycle will dwell on.
    in_d = (state_d == StDrive) ? step_d : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= 3'd0;
      step_q  <= 2'd0;
      in_q    <= 2'b00;
      acc_q   <= 4'h0;
      fail_q  <= 4'h0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      in_q    <= in_d;
      acc_q   <= acc_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start;
    end
  end

  assign in_a      = in_q[1];
  assign in_b      = in_q[0];
  assign step      = step_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_q;

endmodule
